logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Registered, parametrised bitwise logic unit. It is the sequential successor to the team's single-gate combinational primitives. One block selects NOT/AND/OR/XOR/NOR/NAND/XNOR/PASS per beat over WIDTH-bit operands behind a valid/ready handshake. An optional fold mode chains the operation across multiple beats into a single result. It sits between operand producers and the datapath that consumes logic results.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  3  0 NOT a, 1 AND, 2 OR, 3 XOR, 4 NOR, 5 NAND, 6 XNOR, 7 PASS a
- in_fold  in  1  beat belongs to a fold sequence (LOGIC_UNIT_FOLD_EN only)
- in_last  in  1  final beat of a fold sequence (LOGIC_UNIT_FOLD_EN only)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  WIDTH  result
- out_zero  out  1  out_y == 0
- out_parity  out  1  XOR-reduction of out_y

## Operation
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready, registered output stage, full throughput.
- Normal beat (in_fold=0): out_y <= op(in_a, in_b); out_valid <= 1; flags computed from the new out_y.
- Output register holds out_y/flags stable while out_valid && !out_ready. out_valid clears on out_ready when no new beat is accepted.
- Fold FSM, states IDLE and FOLD:
  - IDLE, fold beat, !in_last: acc <= op(in_a, in_b); go to FOLD; no output.
  - IDLE, fold beat, in_last: identical to a normal beat; stay IDLE.
  - FOLD, fold beat, !in_last: acc <= op(acc, in_b), with in_a ignored and NOT/PASS acting on acc; stay FOLD; no output.
  - FOLD, fold beat, in_last: out_y <= op(acc, in_b); out_valid <= 1; go to IDLE.
  - FOLD, non-fold beat: abort. acc is discarded, the beat is processed as a normal beat, go to IDLE.
- in_op is sampled per beat, so mixed ops within one fold are legal.
- Widths: all ops are bitwise over WIDTH; no carries, no truncation.

## Timing
- Reset values: out_valid 0, out_y 0, out_zero 0, out_parity 0, state IDLE, acc 0. in_ready is 1 after reset.
- Latency: result visible on the cycle after the accepting edge (1 cycle).
- Fold result appears 1 cycle after the in_last beat is accepted.
- Non-last fold beats need no output slot, but are still gated by in_ready (uniform rule).
- Simultaneous out_ready and new accept: output is overwritten in the same cycle, and out_valid stays 1.
- Reset mid-fold: asynchronous clear to IDLE; the partial acc is lost and no output is produced.
- in_ready is combinational from out_valid/out_ready only; there is no path from in_valid.

## Configuration
- LOGIC_UNIT_FOLD_EN defined: fold FSM and acc register are present, behaving as above.
- LOGIC_UNIT_FOLD_EN undefined: in_fold/in_last are ignored, and there is no FSM or acc. Every accepted beat produces one output.

## Test plan
- Reset: assert rst_n=0 mid-traffic -> out_valid=0, out_y=0x00, out_zero=0, out_parity=0 immediately; in_ready=1 after release.
- All ops, WIDTH=8, a=0xC5, b=0x0F, op 0..7 back-to-back with out_ready=1 -> out_y=0x3A,0x05,0xCF,0xCA,0x30,0xFA,0x35,0xC5 on consecutive cycles.
- Backpressure: send AND a=0xF0 b=0x0F, hold out_ready=0 for 4 cycles -> out_y=0x00, out_zero=1, held stable; in_ready=0; next beat accepted only after out_ready=1.
- Fold XOR (FOLD_EN): beats (a=0x11,b=0x22), (b=0x44), (b=0x0F, last) -> single output out_y=0x78, out_parity=0, with no output on the first two beats.
- Abort and reset mid-fold: fold beat OR a=0x01 b=0x02, then normal AND a=0xFF b=0x3C -> out_y=0x3C. Separately, reset after the first fold beat, then a fold-last XOR a=0x0A b=0x05 -> out_y=0x0F, with no stale acc.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered bitwise logic unit with optional multi-beat fold
//
// Purpose:
//   Applies one of eight bitwise operations to WIDTH-bit operands per accepted
//   beat and presents the result from a single output register behind a
//   valid/ready handshake. When the LOGIC_UNIT_FOLD_EN macro is defined, a
//   fold sequence chains the operation across several beats through an
//   accumulator and emits one result on the last beat.
//
// Configuration macro:
//   LOGIC_UNIT_FOLD_EN - defined: fold FSM and accumulator present.
//                        undefined: in_fold/in_last ignored, one output per beat.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    input beat valid
//   in_ready    block can accept a beat (depends on out_valid/out_ready only)
//   in_a        operand A (replaced by the accumulator inside a fold)
//   in_b        operand B
//   in_op       0 NOT a, 1 AND, 2 OR, 3 XOR, 4 NOR, 5 NAND, 6 XNOR, 7 PASS a
//   in_fold     beat belongs to a fold sequence
//   in_last     final beat of a fold sequence
//   out_valid   result valid
//   out_ready   consumer accepts result
//   out_y       result
//   out_zero    out_y == 0
//   out_parity  XOR-reduction of out_y

module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_fold,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity
);

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  // Pure bitwise evaluation; PASS (7) is the fall-through case.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XNOR: r = ~(a ^ b);
      default: r = a;
    endcase
    return r;
  endfunction

  logic             accept;
  logic             produce;   // accepted beat that writes the output register
  logic [WIDTH-1:0] op_res;    // result of this beat's operation

  // Output slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef LOGIC_UNIT_FOLD_EN

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic             acc_load;

  // State register (and accumulator, which only moves with the FSM).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Any beat that leaves the fold (last or abort) discards the partial value.
        if (acc_load) acc <= op_res;
        else          acc <= '0;
      end
    end
  end

  // Next-state logic: only a non-last fold beat keeps (or enters) FOLD.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_fold && !in_last) state_nxt = S_FOLD;
      else                     state_nxt = S_IDLE;
    end
  end

  // Output logic: inside a fold the accumulator stands in for operand A,
  // so NOT/PASS act on the running value.
  always_comb begin
    op_a     = in_a;
    produce  = 1'b0;
    acc_load = 1'b0;
    if (state == S_FOLD && in_fold) op_a = acc;
    op_res = apply_op(in_op, op_a, in_b);
    if (accept) begin
      if (in_fold && !in_last) acc_load = 1'b1;
      else                     produce  = 1'b1;
    end
  end

`else

  logic unused_fold_inputs;

  assign unused_fold_inputs = in_fold ^ in_last;
  assign op_res             = apply_op(in_op, in_a, in_b);
  assign produce            = accept;

`endif

  // Output register: a new result overwrites even while being drained, so
  // out_valid stays high across back-to-back accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
    end else if (produce) begin
      out_valid  <= 1'b1;
      out_y      <= op_res;
      out_zero   <= (op_res == '0);
      out_parity <= ^op_res;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - directed self-checking bench for logic_unit_pipe

module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_fold;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;
  logic       out_parity;

  int total;
  int bad;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_fold    (in_fold),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_zero   (out_zero),
    .out_parity (out_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain();
    in_valid  = 1'b0;
    in_fold   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'hA5; in_b = 8'h00; out_ready = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b1 || out_y !== 8'hA5) begin
      bad++; $display("FAIL reset_pre got v=%b y=%h want v=1 y=a5", out_valid, out_y);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || out_zero !== 1'b0 || out_parity !== 1'b0) begin
      bad++; $display("FAIL reset_async got v=%b y=%h z=%b p=%b want 0 00 0 0",
                      out_valid, out_y, out_zero, out_parity);
    end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_y [8];
    exp_y = '{8'h3A, 8'h05, 8'hCF, 8'hCA, 8'h30, 8'hFA, 8'h35, 8'hC5};
    idle_drain();
    in_a = 8'hC5; in_b = 8'h0F; in_fold = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_op    = 3'(i);
      step();
      total++;
      if (out_valid !== 1'b1 || out_y !== exp_y[i] || out_zero !== 1'b0 || out_parity !== 1'b0) begin
        bad++; $display("FAIL op%0d got v=%b y=%h z=%b p=%b want v=1 y=%h z=0 p=0",
                        i, out_valid, out_y, out_zero, out_parity, exp_y[i]);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL ops_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    idle_drain();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd1; in_a = 8'hF0; in_b = 8'h0F;
    step();
    in_op = 3'd2; in_a = 8'h12; in_b = 8'h20;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_y !== 8'h00 || out_zero !== 1'b1 || out_parity !== 1'b0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got v=%b y=%h z=%b p=%b rdy=%b want 1 00 1 0 0",
                        i, out_valid, out_y, out_zero, out_parity, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_y !== 8'h00) begin
      bad++; $display("FAIL bp_release got rdy=%b y=%h want rdy=1 y=00", in_ready, out_y);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_y !== 8'h32 || out_zero !== 1'b0 || out_parity !== 1'b1) begin
      bad++; $display("FAIL bp_next got v=%b y=%h z=%b p=%b want 1 32 0 1",
                      out_valid, out_y, out_zero, out_parity);
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_fold();
    logic [7:0] exp_y [3];
    logic       exp_v [3];
`ifdef LOGIC_UNIT_FOLD_EN
    exp_v = '{1'b0, 1'b0, 1'b1};
    exp_y = '{8'h00, 8'h00, 8'h78};
`else
    exp_v = '{1'b1, 1'b1, 1'b1};
    exp_y = '{8'h33, 8'hBB, 8'hF0};
`endif
    idle_drain();
    in_valid = 1'b1; in_op = 3'd3; in_fold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a    = (i == 0) ? 8'h11 : 8'hFF;
      in_b    = (i == 0) ? 8'h22 : ((i == 1) ? 8'h44 : 8'h0F);
      in_last = (i == 2);
      step();
      total++;
      if (out_valid !== exp_v[i] || (exp_v[i] && out_y !== exp_y[i])) begin
        bad++; $display("FAIL fold_beat%0d got v=%b y=%h want v=%b y=%h",
                        i, out_valid, out_y, exp_v[i], exp_y[i]);
      end
    end
    total++;
    if (out_parity !== 1'b0) begin
      bad++; $display("FAIL fold_parity got %b want 0", out_parity);
    end
    idle_drain();
  endtask

  task automatic test_abort_and_reset();
    logic exp_v1;
`ifdef LOGIC_UNIT_FOLD_EN
    exp_v1 = 1'b0;
`else
    exp_v1 = 1'b1;
`endif
    idle_drain();
    in_valid = 1'b1; in_fold = 1'b1; in_last = 1'b0; in_op = 3'd2; in_a = 8'h01; in_b = 8'h02;
    step();
    total++;
    if (out_valid !== exp_v1 || (exp_v1 && out_y !== 8'h03)) begin
      bad++; $display("FAIL abort_first got v=%b y=%h want v=%b", out_valid, out_y, exp_v1);
    end
    in_fold = 1'b0; in_op = 3'd1; in_a = 8'hFF; in_b = 8'h3C;
    step();
    total++;
    if (out_valid !== 1'b1 || out_y !== 8'h3C) begin
      bad++; $display("FAIL abort_normal got v=%b y=%h want v=1 y=3c", out_valid, out_y);
    end
    in_fold = 1'b1; in_last = 1'b0; in_op = 3'd3; in_a = 8'h50; in_b = 8'h05;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL fold_reset got v=%b want 0", out_valid);
    end
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_fold = 1'b1; in_last = 1'b1; in_op = 3'd3; in_a = 8'h0A; in_b = 8'h05;
    step();
    total++;
    if (out_valid !== 1'b1 || out_y !== 8'h0F) begin
      bad++; $display("FAIL fold_after_reset got v=%b y=%h want v=1 y=0f", out_valid, out_y);
    end
    idle_drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_fold = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || out_zero !== 1'b0 || out_parity !== 1'b0) begin
      bad++; $display("FAIL por got v=%b y=%h z=%b p=%b want 0 00 0 0",
                      out_valid, out_y, out_zero, out_parity);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL por_ready got %b want 1", in_ready);
    end
    test_reset();
    test_all_ops();
    test_backpressure();
    test_fold();
    test_abort_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
